// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the round sequencer.
// Byte i of a state/word sits at array index i, i.e. FIPS-197 column-major order.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef byte_t [0:15] state_t;
  typedef byte_t [0:3]  word_t;

  localparam int    AES_NR    = 10;
  localparam byte_t RCON_INIT = 8'h01;

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c + r] = s[4*((c + r) % 4) + r];
      end
    end
    return o;
  endfunction

  function automatic word_t mix_column(input word_t a);
    word_t b;
    b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    return b;
  endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// Combinational MixColumns over all four columns of an AES state.
module aes_mixcolumns
  import aes_pkg::*;
(
  input  state_t data,
  output state_t mixed
);

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[4*c +: 4] = mix_column(data[4*c +: 4]);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer, one round per clock, external S-box.
// Optional completed-block counter (blk_cnt) enabled by defining AES_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// ROUND | one cipher round + key expansion step per cycle
// DONE  | ciphertext on out_text; out_valid held until out_ready
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_text,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_text,
  output state_t           sbox_state_o,
  input  state_t           sbox_state_i,
  output word_t            sbox_key_o,
  input  word_t            sbox_key_i
`ifdef AES_PERF_CNT_EN
  ,
  output logic [31:0]      blk_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t       fsm, fsm_nxt;
  state_t     st, st_nxt;
  state_t     rk, rk_nxt, nrk;
  state_t     sr, mc;
  byte_t      rcon, rcon_nxt;
  logic [3:0] round, round_nxt;
  logic       out_valid_nxt;
  word_t      w0, w1, w2, w3;

  assign in_ready     = (fsm == IDLE);
  assign out_text     = st;
  assign sbox_state_o = st;
  assign sr           = shift_rows(sbox_state_i);

  aes_mixcolumns u_mixcolumns (
    .data  (sr),
    .mixed (mc)
  );

  // Next round key from the current one; S-box sees RotWord(w3).
  always_comb begin
    sbox_key_o = {rk[13], rk[14], rk[15], rk[12]};
    w0  = rk[0:3] ^ sbox_key_i ^ {rcon, 24'h0};
    w1  = rk[4:7] ^ w0;
    w2  = rk[8:11] ^ w1;
    w3  = rk[12:15] ^ w2;
    nrk = {w0, w1, w2, w3};
  end

  always_comb begin
    fsm_nxt       = fsm;
    st_nxt        = st;
    rk_nxt        = rk;
    rcon_nxt      = rcon;
    round_nxt     = round;
    out_valid_nxt = out_valid;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          st_nxt    = in_text ^ in_key;
          rk_nxt    = in_key;
          round_nxt = 4'd1;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        st_nxt    = (round == LAST_ROUND) ? (sr ^ nrk) : (mc ^ nrk);
        rk_nxt    = nrk;
        rcon_nxt  = xtime(rcon);
        round_nxt = round + 4'd1;
        if (round == LAST_ROUND) begin
          fsm_nxt       = DONE;
          out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          fsm_nxt       = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      st        <= '0;
      rk        <= '0;
      rcon      <= RCON_INIT;
      round     <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      st        <= st_nxt;
      rk        <= rk_nxt;
      rcon      <= rcon_nxt;
      round     <= round_nxt;
      out_valid <= out_valid_nxt;
    end
  end

`ifdef AES_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a behavioural S-box and AES-128 reference model.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic [127:0] sbox_so;
  logic [127:0] sbox_si;
  logic [31:0]  sbox_ko;
  logic [31:0]  sbox_ki;
`ifdef AES_PERF_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];

  aes_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_text      (in_text),
    .in_key       (in_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_text     (out_text),
    .sbox_state_o (sbox_so),
    .sbox_state_i (sbox_si),
    .sbox_key_o   (sbox_ko),
    .sbox_key_i   (sbox_ki)
`ifdef AES_PERF_CNT_EN
    ,
    .blk_cnt      (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p = x;
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    return b ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] k [0:175];
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] tmp [0:3];
    logic [7:0] rc = 8'h01;
    logic [7:0] x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = k[i-4+j];
      if (i % 16 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_f(tmp[1]) ^ rc;
        tmp[1] = sbox_f(tmp[2]);
        tmp[2] = sbox_f(tmp[3]);
        tmp[3] = sbox_f(x);
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ tmp[j];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_f(s[(i + 4*(i % 4)) % 16]);
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[16*rd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  always_comb begin
    sbox_si = '0;
    sbox_ki = '0;
    for (int i = 0; i < 16; i++) sbox_si[127-8*i -: 8] = sbox_f(sbox_so[127-8*i -: 8]);
    for (int i = 0; i < 4; i++) sbox_ki[31-8*i -: 8] = sbox_f(sbox_ko[31-8*i -: 8]);
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid&&ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", out_text);
      end else begin
        chk("out_text", out_text, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_text  = pt;
    in_key   = key;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_text  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        timeout("send");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain(input bit rand_rdy);
    int n = 0;
    while (exp_q.size() != 0) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (n > 300) begin
        timeout("drain");
        exp_q.delete();
      end
    end
    out_ready = 1'b1;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held, pt, key;
    int n;
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_text   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out_text", out_text, 128'd0);
`ifdef AES_PERF_CNT_EN
    chk("reset_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // C.1 with latency measurement
    send(C1_PT, C1_KEY, C1_CT);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_cycles", 128'(n), 128'd10);
    drain(1'b0);

    // Appendix B
    send(B_PT, B_KEY, B_CT);
    drain(1'b0);

    // Backpressure
    out_ready = 1'b0;
    send(C1_PT, B_KEY, aes_ref(C1_PT, B_KEY));
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = out_text;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_text !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    chk("backpressure_hold", 128'(ok), 128'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_xfer_in_ready", 128'(in_ready), 128'd1);
    chk("after_xfer_out_valid", 128'(out_valid), 128'd0);
    chk("single_transfer", 128'(exp_q.size()), 128'd0);

    // Busy-input rejection
    send(B_PT, C1_KEY, aes_ref(B_PT, C1_KEY));
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      in_text  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (in_ready !== 1'b0) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("busy_in_ready_low", 128'(ok), 128'd1);
    drain(1'b0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("no_second_block", 128'(ok), 128'd1);

    // Async reset in round 5
    send(C1_PT, C1_KEY, C1_CT);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    drain(1'b0);

    // Randomized blocks with random consumer stalls
    for (int b = 0; b < 8; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key, aes_ref(pt, key));
      drain(1'b1);
    end

`ifdef AES_PERF_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < 3; b++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key, aes_ref(pt, key));
      drain(1'b0);
    end
    chk("blk_cnt_three", 128'(blk_cnt), 128'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("blk_cnt_cleared", 128'(blk_cnt), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
